// File: rtl/temporal2binary.sv
// temporal2binary: converts rising-edge temporal-coded spikes into binary
// arrival times, one frame per gamma cycle. The phase counter runs while en
// is high, and each wrap closes a frame. The first rising edge per channel
// is time-stamped with the current phase. A closed frame goes to a
// valid/ready output register.
//
// Output handshake: a frame is held on times/spiked while out_valid=1. The
// frame is transferred on an aclk edge where out_valid=1 and out_ready=1.
// While out_valid=1 and out_ready=0, times/spiked do not change. out_ready
// is ignored while out_valid=0. If a frame closes while the held frame has
// not been accepted, the new frame is dropped and overrun latches.
module temporal2binary #(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int NUM_INPUTS        = 16,
    parameter int VALUE_WIDTH       = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic                              aclk,
    input  logic                              grst,
    input  logic                              en,
    input  logic [NUM_INPUTS-1:0]             inputs,
    output logic [VALUE_WIDTH-1:0]            phase,
    output logic [NUM_INPUTS*VALUE_WIDTH-1:0] times,
    output logic [NUM_INPUTS-1:0]             spiked,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              overrun
);

    localparam logic [VALUE_WIDTH-1:0] LAST_PHASE = VALUE_WIDTH'(GAMMA_CYCLE_WIDTH - 1);

    // Capture state for the frame in progress
    logic [NUM_INPUTS-1:0]             prev_in;   // samples taken at the previous edge of this frame
    logic [NUM_INPUTS-1:0]             fired;     // channel already has its first event this frame
    logic [VALUE_WIDTH-1:0]            cap_time [NUM_INPUTS];

    // Combinational view of the current edge
    logic                              frame_close;
    logic [NUM_INPUTS-1:0]             event_hit;
    logic [NUM_INPUTS-1:0]             result_spiked;
    logic [NUM_INPUTS*VALUE_WIDTH-1:0] result_times;
    logic                              load_result;

    assign frame_close = en && (phase == LAST_PHASE);

    // Per-channel first-event detection, and the frame result including this edge's samples
    always_comb begin
        event_hit     = '0;
        result_spiked = '0;
        result_times  = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            // At phase 0 a high level counts as an edge, so a channel held
            // across the boundary fires at time 0 of the new frame.
            event_hit[i] = inputs[i] && ((phase == '0) || !prev_in[i]) && !fired[i];
            result_spiked[i] = fired[i] || event_hit[i];
            if (fired[i]) begin
                result_times[i*VALUE_WIDTH +: VALUE_WIDTH] = cap_time[i];
            end else if (event_hit[i]) begin
                result_times[i*VALUE_WIDTH +: VALUE_WIDTH] = phase;
            end
        end
    end

    // A closed frame is accepted if the output slot is free or being drained on this edge
    assign load_result = frame_close && (!out_valid || out_ready);

    // Gamma phase counter: runs with en, wraps at the end of each gamma cycle, parks at 0 otherwise
    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            phase <= '0;
        end else if (!en) begin
            phase <= '0;
        end else if (phase == LAST_PHASE) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

    // Capture state: records first events, cleared on frame close and whenever en is low
    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            prev_in <= '0;
            fired   <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                cap_time[i] <= '0;
            end
        end else if (!en || frame_close) begin
            // The closing edge's samples are already folded into the result,
            // and the next frame starts at phase 0 where prev_in is not used.
            prev_in <= '0;
            fired   <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                cap_time[i] <= '0;
            end
        end else begin
            prev_in <= inputs;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (event_hit[i]) begin
                    fired[i]    <= 1'b1;
                    cap_time[i] <= phase;
                end
            end
        end
    end

    // Output register: load on accepted close, drain on handshake, hold otherwise
    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            times     <= '0;
            spiked    <= '0;
            out_valid <= 1'b0;
        end else if (load_result) begin
            times     <= result_times;
            spiked    <= result_spiked;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky overrun: a closed frame found the held frame still unaccepted
    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            overrun <= 1'b0;
        end else if (frame_close && out_valid && !out_ready) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_temporal2binary.sv
// Directed bench for temporal2binary with G=16, N=4 (4-bit time stamps).
// Inputs are driven 1 time unit after each rising edge and checked there.
module tb_temporal2binary;

    localparam int G  = 16;
    localparam int N  = 4;
    localparam int VW = 4;

    logic            aclk;
    logic            grst;
    logic            en;
    logic [N-1:0]    inputs;
    logic [VW-1:0]   phase;
    logic [N*VW-1:0] times;
    logic [N-1:0]    spiked;
    logic            out_valid;
    logic            out_ready;
    logic            overrun;

    int checks = 0;
    int errors = 0;

    temporal2binary #(
        .GAMMA_CYCLE_WIDTH(G),
        .NUM_INPUTS       (N),
        .VALUE_WIDTH      (VW)
    ) dut (
        .aclk     (aclk),
        .grst     (grst),
        .en       (en),
        .inputs   (inputs),
        .phase    (phase),
        .times    (times),
        .spiked   (spiked),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overrun  (overrun)
    );

    // Clock: period 10, rising edges at 5, 15, 25, ...
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Input pattern for frame kind k at phase p (value sampled at edge E_p)
    function automatic logic [N-1:0] pat(input int k, input int p);
        logic [N-1:0] v;
        v = '0;
        case (k)
            1: begin v[0] = (p >= 3); v[1] = (p <= 1); v[2] = (p == 15); end
            2: v[0] = 1'b1;
            3: begin v[0] = (p == 5) || (p == 9) || (p == 10); v[3] = (p == 7) || (p == 9); end
            4: v[1] = (p >= 2) && (p <= 4);
            5: v[2] = (p >= 4);
            6: v[3] = (p >= 6) && (p <= 8);
            7: v[0] = (p >= 3);
            8: v[0] = (p >= 9);
            9: v[1] = 1'b1;
            10: v[2] = (p >= 1);
            default: v = '0;
        endcase
        return v;
    endfunction

    // Drive enabled edges E_first..E_last of a frame of kind k
    task automatic run_frame(input int k, input int first_p, input int last_p,
                             input logic rdy, input logic rdy_last);
        for (int p = first_p; p <= last_p; p++) begin
            en        = 1'b1;
            inputs    = pat(k, p);
            out_ready = (p == G - 1) ? rdy_last : rdy;
            tick();
        end
    endtask

    initial begin
        grst      = 1'b1;
        en        = 1'b0;
        inputs    = '0;
        out_ready = 1'b0;
        #1;
        check("rst_phase", 32'(phase), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_times", 32'(times), 32'h0);
        check("rst_spiked", 32'(spiked), 32'h0);
        tick();
        tick();
        grst = 1'b0;

        // Basic frame: ch0@3, ch1@0, ch2@15, ch3 silent
        run_frame(1, 0, 14, 1'b0, 1'b0);
        check("f1_not_yet_valid", 32'(out_valid), 32'h0);
        check("f1_phase15", 32'(phase), 32'hF);
        run_frame(1, 15, 15, 1'b0, 1'b0);
        check("f1_valid", 32'(out_valid), 32'h1);
        check("f1_times", 32'(times), 32'h0F03);
        check("f1_spiked", 32'(spiked), 32'b0111);
        check("f1_phase_wrap", 32'(phase), 32'h0);

        // ch0 held high through the wrap; handshake drains frame 1 at E_0
        run_frame(2, 0, 0, 1'b1, 1'b1);
        check("f2_drained", 32'(out_valid), 32'h0);
        run_frame(2, 1, 15, 1'b1, 1'b1);
        check("f2_valid", 32'(out_valid), 32'h1);
        check("f2_times", 32'(times), 32'h0000);
        check("f2_spiked", 32'(spiked), 32'b0001);

        // First event only: ch0 pulses at 5 then again at 9; ch3 at 7 then 9
        run_frame(3, 0, 15, 1'b1, 1'b1);
        check("f3_times", 32'(times), 32'h7005);
        check("f3_spiked", 32'(spiked), 32'b1001);

        // Frame A loads, frame B is dropped while A is held
        run_frame(4, 0, 15, 1'b1, 1'b1);
        check("fa_times", 32'(times), 32'h0020);
        check("fa_overrun", 32'(overrun), 32'h0);
        run_frame(5, 0, 15, 1'b0, 1'b0);
        check("fb_held_times", 32'(times), 32'h0020);
        check("fb_held_spiked", 32'(spiked), 32'b0010);
        check("fb_valid", 32'(out_valid), 32'h1);
        check("fb_overrun", 32'(overrun), 32'h1);
        // Frame C closes on the same edge the held frame is accepted
        run_frame(6, 0, 14, 1'b0, 1'b0);
        check("fc_still_held", 32'(times), 32'h0020);
        run_frame(6, 15, 15, 1'b0, 1'b1);
        check("fc_times", 32'(times), 32'h6000);
        check("fc_spiked", 32'(spiked), 32'b1000);
        check("fc_valid", 32'(out_valid), 32'h1);
        check("fc_overrun_sticky", 32'(overrun), 32'h1);

        // Frame D aborted at phase 7 after ch0 fired at 3
        run_frame(7, 0, 6, 1'b1, 1'b1);
        check("fd_phase7", 32'(phase), 32'h7);
        check("fd_drained", 32'(out_valid), 32'h0);
        en        = 1'b0;
        inputs    = 4'b0001;
        out_ready = 1'b0;
        repeat (5) tick();
        check("fd_phase_parked", 32'(phase), 32'h0);
        check("fd_not_emitted", 32'(out_valid), 32'h0);
        run_frame(8, 0, 14, 1'b0, 1'b0);
        check("fe_not_yet_valid", 32'(out_valid), 32'h0);
        run_frame(8, 15, 15, 1'b0, 1'b0);
        check("fe_times", 32'(times), 32'h0009);
        check("fe_spiked", 32'(spiked), 32'b0001);

        // Reset pulse at phase 10 while a frame is held
        run_frame(9, 0, 9, 1'b0, 1'b0);
        check("ff_phase10", 32'(phase), 32'hA);
        check("ff_valid_before_rst", 32'(out_valid), 32'h1);
        grst = 1'b1;
        #2;
        check("rst2_phase", 32'(phase), 32'h0);
        check("rst2_times", 32'(times), 32'h0);
        check("rst2_spiked", 32'(spiked), 32'h0);
        check("rst2_valid", 32'(out_valid), 32'h0);
        check("rst2_overrun", 32'(overrun), 32'h0);
        #2;
        grst = 1'b0;
        run_frame(10, 0, 14, 1'b0, 1'b0);
        check("fg_not_yet_valid", 32'(out_valid), 32'h0);
        run_frame(10, 15, 15, 1'b0, 1'b0);
        check("fg_valid", 32'(out_valid), 32'h1);
        check("fg_times", 32'(times), 32'h0100);
        check("fg_spiked", 32'(spiked), 32'b0100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/temporal2binary.md
TEMPORAL2BINARY -- requirements
Module: temporal2binary

Interface
REQ-001 SHALL have parameter GAMMA_CYCLE_WIDTH, default 16: number of aclk cycles per gamma cycle; legal values are powers of two, 2 or greater.
REQ-002 SHALL have parameter NUM_INPUTS, default 16: number of temporal-coded input channels.
REQ-003 SHALL have parameter VALUE_WIDTH, default $clog2(GAMMA_CYCLE_WIDTH): width of each binary time stamp.
REQ-004 SHALL have port aclk, input, 1 bit: clock; all state changes on its rising edge.
REQ-005 SHALL have port grst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port en, input, 1 bit: frame enable; gamma phase counter runs only while high.
REQ-007 SHALL have port inputs, input, NUM_INPUTS bits: rising-edge temporal-coded spikes, one per channel.
REQ-008 SHALL have port phase, output, VALUE_WIDTH bits: current gamma phase, 0..GAMMA_CYCLE_WIDTH-1.
REQ-009 SHALL have port times, output, NUM_INPUTS*VALUE_WIDTH bits: binary arrival time per channel; channel i occupies bits [i*VALUE_WIDTH +: VALUE_WIDTH].
REQ-010 SHALL have port spiked, output, NUM_INPUTS bits: 1 = channel fired in the frame; 0 = no spike ("infinity"), with that channel's times field forced to 0.
REQ-011 SHALL have port out_valid, output, 1 bit: a result frame is held on times/spiked.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts the frame.
REQ-013 SHALL have port overrun, output, 1 bit: sticky flag, set when a completed frame was dropped.

Function
REQ-014 SHALL, while en=1, increment phase by 1 at every aclk edge, wrapping from GAMMA_CYCLE_WIDTH-1 to 0; each wrap closes one frame.
REQ-015 SHALL, while en=0, hold phase at 0 and discard all partial-frame capture state; times, spiked, out_valid, out_ready handling and overrun are unaffected.
REQ-016 SHALL define the sample at edge E_p as the value of inputs at the aclk edge where phase==p (pre-edge value) and en=1.
REQ-017 SHALL record a channel event at E_p when the channel samples 1 and either p==0 or it sampled 0 at E_(p-1); the time stamp recorded is p.
REQ-018 SHALL keep only the first event per channel per frame; later edges, glitches and levels in the same frame are ignored.
REQ-019 SHALL treat a channel held high across a frame boundary as an event at time 0 of the new frame.
REQ-020 SHALL, at E_(GAMMA_CYCLE_WIDTH-1), form the frame result including samples taken at that same edge, and clear capture state for the next frame in the same edge.
REQ-021 SHALL, if out_valid=0 or (out_valid=1 and out_ready=1) at frame close, load the result into times/spiked and drive out_valid=1 from the next cycle.
REQ-022 SHALL, if out_valid=1 and out_ready=0 at frame close, keep the held frame unchanged, drop the new frame, and set overrun=1.
REQ-023 SHALL clear out_valid on an edge with out_valid=1 and out_ready=1 unless a new frame closes on that same edge (REQ-021).
REQ-024 SHALL keep times/spiked stable while out_valid=1 and out_ready=0.
REQ-025 SHALL ignore out_ready while out_valid=0.
REQ-026 SHALL keep overrun at 1 until grst.

Reset
REQ-027 SHALL, on grst=1, asynchronously set phase=0, times=0, spiked=0, out_valid=0 and overrun=0, and clear all capture state.
REQ-028 SHALL, on grst deassertion mid-frame, start a fresh frame at phase 0 on the first edge with en=1; no partial frame is ever emitted.

Verification
REQ-029 SHALL cover: G=16, N=4, en=1, ch0 rises at E_3, ch1 at E_0, ch2 at E_15, ch3 never -> times={0,15,0,3} (ch3..ch0), spiked=4'b0111, out_valid=1 one cycle after E_15.
REQ-030 SHALL cover: ch0 pulses at E_5, falls, rises again at E_9 -> times[ch0]=5.
REQ-031 SHALL cover: ch0 held high through the wrap -> next frame times[ch0]=0, spiked[0]=1.
REQ-032 SHALL cover: out_ready=0 across two frame closes -> first frame held unchanged, overrun=1; out_ready=1 on the edge of the third frame close -> third frame loaded, out_valid stays 1.
REQ-033 SHALL cover: en dropped at phase 7 with ch0 already fired, re-raised later -> aborted frame never emitted; next frame timed from phase 0.
REQ-034 SHALL cover: grst pulsed at phase 10 while out_valid=1 -> all outputs 0 immediately; first result appears 16 enabled cycles after release.
